// File: rtl/counter_checker.sv
// Reference-model monitor for an enable-gated up-counter: tracks the expected count and
// reports mismatches, a saturating error tally, the first failing sample and wrap events.
module counter_checker #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     clear,
  output logic [WIDTH-1:0]         expected,
  output logic                     locked,
  output logic                     mismatch,
  output logic                     error_sticky,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic [WIDTH-1:0]         first_bad_value,
  output logic [WIDTH-1:0]         first_bad_expected,
  output logic                     wrap
);

  typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

  state_e                   r_state;
  logic [WIDTH-1:0]         r_expected;
  logic                     r_mismatch;
  logic                     r_wrap;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;
  logic [WIDTH-1:0]         r_first_bad_value;
  logic [WIDTH-1:0]         r_first_bad_expected;

  logic [WIDTH-1:0]         w_resync;
  logic [WIDTH-1:0]         w_advance;
  logic                     w_match;
  logic                     w_at_max;
  logic [ERR_CNT_WIDTH-1:0] w_err_inc;

  assign w_resync  = count_in + WIDTH'(enable);
  assign w_advance = r_expected + WIDTH'(enable);
  assign w_match   = (count_in == r_expected);
  assign w_at_max  = (r_expected == '1);
  assign w_err_inc = (r_err_count == '1) ? r_err_count : r_err_count + ERR_CNT_WIDTH'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state              <= StIdle;
      r_expected           <= '0;
      r_mismatch           <= 1'b0;
      r_wrap               <= 1'b0;
      r_err_count          <= '0;
      r_first_bad_value    <= '0;
      r_first_bad_expected <= '0;
    end else begin
      r_mismatch <= 1'b0;
      r_wrap     <= 1'b0;
      case (r_state)
        StIdle: begin
          r_expected <= w_resync;
          r_state    <= StTrack;
        end
        default: begin
          if (!w_match) begin
            r_mismatch <= 1'b1;
            r_expected <= w_resync;
            r_state    <= StFault;
            // A clear on a mismatch edge restarts the tally with this failure as the first.
            if (clear) begin
              r_err_count <= ERR_CNT_WIDTH'(1);
            end else begin
              r_err_count <= w_err_inc;
            end
            if (clear || (r_state == StTrack)) begin
              r_first_bad_value    <= count_in;
              r_first_bad_expected <= r_expected;
            end
          end else begin
            r_expected <= w_advance;
            r_wrap     <= enable && w_at_max;
            if (clear) begin
              r_err_count          <= '0;
              r_first_bad_value    <= '0;
              r_first_bad_expected <= '0;
              r_state              <= StTrack;
            end
          end
        end
      endcase
    end
  end

  assign expected           = r_expected;
  assign locked             = (r_state != StIdle);
  assign mismatch           = r_mismatch;
  assign error_sticky       = (r_state == StFault);
  assign error_count        = r_err_count;
  assign first_bad_value    = r_first_bad_value;
  assign first_bad_expected = r_first_bad_expected;
  assign wrap               = r_wrap;

endmodule

// File: tb/tb_counter_checker.sv
// Directed and randomized bench for counter_checker against an arithmetic reference model.
module tb_counter_checker;

  localparam int unsigned W    = 4;
  localparam int unsigned EW   = 2;
  localparam int          MODV = 16;
  localparam int          EMAX = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [W-1:0]  count_in;
  logic          clear;
  logic [W-1:0]  expected;
  logic          locked;
  logic          mismatch;
  logic          error_sticky;
  logic [EW-1:0] error_count;
  logic [W-1:0]  first_bad_value;
  logic [W-1:0]  first_bad_expected;
  logic          wrap;

  counter_checker #(
    .WIDTH        (W),
    .ERR_CNT_WIDTH(EW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .count_in          (count_in),
    .clear             (clear),
    .expected          (expected),
    .locked            (locked),
    .mismatch          (mismatch),
    .error_sticky      (error_sticky),
    .error_count       (error_count),
    .first_bad_value   (first_bad_value),
    .first_bad_expected(first_bad_expected),
    .wrap              (wrap)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, kept as plain integers.
  int m_locked, m_exp, m_mis, m_sticky, m_err, m_fbv, m_fbe, m_wrap;

  task automatic model_reset();
    m_locked = 0; m_exp = 0; m_mis = 0; m_sticky = 0;
    m_err = 0; m_fbv = 0; m_fbe = 0; m_wrap = 0;
  endtask

  task automatic model_step(input int en, input int cnt, input int clr);
    m_mis  = 0;
    m_wrap = 0;
    if (m_locked == 0) begin
      m_exp    = (cnt + en) % MODV;
      m_locked = 1;
    end else if (cnt != m_exp) begin
      m_mis = 1;
      if (clr != 0 || m_sticky == 0) begin
        m_fbv = cnt;
        m_fbe = m_exp;
      end
      m_err    = (clr != 0) ? 1 : ((m_err < EMAX) ? m_err + 1 : EMAX);
      m_sticky = 1;
      m_exp    = (cnt + en) % MODV;
    end else begin
      m_wrap = (en != 0 && m_exp == MODV - 1) ? 1 : 0;
      m_exp  = (m_exp + en) % MODV;
      if (clr != 0) begin
        m_err = 0; m_fbv = 0; m_fbe = 0; m_sticky = 0;
      end
    end
  endtask

  task automatic cmp(input string tag, input int obs, input int exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".expected"}, int'(expected), m_exp);
    cmp({tag, ".locked"}, int'(locked), m_locked);
    cmp({tag, ".mismatch"}, int'(mismatch), m_mis);
    cmp({tag, ".sticky"}, int'(error_sticky), m_sticky);
    cmp({tag, ".err_cnt"}, int'(error_count), m_err);
    cmp({tag, ".fbv"}, int'(first_bad_value), m_fbv);
    cmp({tag, ".fbe"}, int'(first_bad_expected), m_fbe);
    cmp({tag, ".wrap"}, int'(wrap), m_wrap);
  endtask

  // Drive inputs away from the edge, clock once, then check 1 time unit later.
  task automatic step(input string tag, input int en, input int cnt, input int clr);
    enable   = en[0];
    count_in = cnt[W-1:0];
    clear    = clr[0];
    @(posedge clock);
    model_step(en, cnt % MODV, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int wraps;
    int sat_want[5];
    sat_want = '{1, 2, 3, 3, 3};

    reset = 1'b1; enable = 1'b0; count_in = '0; clear = 1'b0;
    model_reset();
    #2;
    check_all("reset_async");
    @(posedge clock);
    #1;
    check_all("reset_held");

    // Correct counter from 0 with enable high: one wrap at 15 -> 0, never a mismatch.
    reset = 1'b0;
    wraps = 0;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      step("count_run", 1, c, 0);
      if (wrap) wraps++;
      c = (c + 1) % MODV;
    end
    cmp("wrap_pulses", wraps, 1);

    // Single corrupted sample while expected=5, then counter continues at 8.
    step("pre_inject", 1, 4, 0);
    cmp("exp_is_5", int'(expected), 5);
    step("inject", 1, 7, 0);
    cmp("inj_fbv", int'(first_bad_value), 7);
    cmp("inj_fbe", int'(first_bad_expected), 5);
    step("resume8", 1, 8, 0);
    step("resume9", 1, 9, 0);

    // Enable low: held count matches, any change mismatches.
    step("hold_sync", 0, 3, 0);
    for (int i = 0; i < 10; i++) step("hold3", 0, 3, 0);
    step("step_to_4", 0, 4, 0);
    cmp("err_is_3", int'(error_count), 3);

    // Clear on a matching edge, then clear coinciding with a mismatch.
    step("clear", 0, 4, 1);
    cmp("clr_err0", int'(error_count), 0);
    cmp("clr_sticky0", int'(error_sticky), 0);
    step("clear_mis", 0, 6, 1);
    cmp("clrmis_err1", int'(error_count), 1);
    cmp("clrmis_sticky", int'(error_sticky), 1);

    // Saturation: clear, then five back-to-back mismatches.
    step("sat_clear", 1, m_exp, 1);
    for (int i = 0; i < 5; i++) begin
      step("sat_inj", 1, (m_exp + 3) % MODV, 0);
      cmp("sat_seq", int'(error_count), sat_want[i]);
    end
    step("sat_ok", 1, m_exp, 0);

    // Randomized traffic: mostly correct samples, occasional corruption and clears.
    for (int i = 0; i < 400; i++) begin
      int en, cnt, clr;
      en  = int'($urandom_range(0, 1));
      cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MODV - 1)) : m_exp;
      clr = ($urandom_range(0, 7) == 0) ? 1 : 0;
      step("random", en, cnt, clr);
    end

    // Reset mid-cycle: outputs drop immediately, next edge locks without flagging.
    step("pre_reset_mis", 1, (m_exp + 5) % MODV, 0);
    reset = 1'b1;
    model_reset();
    #2;
    check_all("reset_mid");
    reset = 1'b0;
    step("relock", 1, 9, 0);
    cmp("relock_exp10", int'(expected), 10);
    step("after_relock", 1, 10, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
